// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr
// Purpose  : N-client arbiter that shares one line-wide downstream memory
//            (physical memory or L2) between several L1 caches. Supports
//            round-robin or fixed-priority winner selection. The downstream
//            request and the client response are both registered.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_PORTS  number of clients (2..8); port 0 = icache, port 1 = dcache
//   LINE_W     line width in bits
//   ADDR_W     address width in bits
//   RR_MODE    1 = round-robin, 0 = fixed priority (lowest index wins)
// Ports
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   cli_read_i     per-client read request (level, held until response)
//   cli_write_i    per-client write request (level, held until response)
//   cli_address_i  client i address at [i*ADDR_W +: ADDR_W]
//   cli_wdata_i    client i write line at [i*LINE_W +: LINE_W]
//   cli_resp_o     one-cycle completion pulse to the granted client
//   cli_rdata_o    read line, valid with cli_resp_o, shared by all clients
//   mem_read_o     downstream read request
//   mem_write_o    downstream write request
//   mem_address_o  downstream address
//   mem_wdata_o    downstream write line
//   mem_resp_i     downstream completion (one cycle)
//   mem_rdata_i    downstream read line, valid with mem_resp_i
//   busy_o         high whenever a transaction is outstanding
//   grant_id_o     index of the client currently or last served
// ============================================================================
module mem_arbiter_rr #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32,
  parameter bit RR_MODE   = 1'b1,
  localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        cli_read_i,
  input  logic [NUM_PORTS-1:0]        cli_write_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] cli_address_i,
  input  logic [NUM_PORTS*LINE_W-1:0] cli_wdata_i,
  output logic [NUM_PORTS-1:0]        cli_resp_o,
  output logic [LINE_W-1:0]           cli_rdata_o,
  output logic                        mem_read_o,
  output logic                        mem_write_o,
  output logic [ADDR_W-1:0]           mem_address_o,
  output logic [LINE_W-1:0]           mem_wdata_o,
  input  logic                        mem_resp_i,
  input  logic [LINE_W-1:0]           mem_rdata_i,
  output logic                        busy_o,
  output logic [ID_W-1:0]             grant_id_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [NUM_PORTS-1:0] ONE_HOT_LSB = NUM_PORTS'(1);
  localparam logic [ID_W-1:0]      LAST_ID     = ID_W'(NUM_PORTS - 1);

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_e                 state_q;
  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        grant_id_q;
  logic                   op_write_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [LINE_W-1:0]      wdata_q;
  logic [LINE_W-1:0]      rdata_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [NUM_PORTS-1:0]   cli_resp_q;
  logic                   busy_q;

  // --------------------------------------------------------------------------
  // Arbitration (combinational, only consumed in IDLE)
  // --------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]   req;
  logic                   any_req;
  logic                   found;
  int                     scan_idx;
  logic [ID_W-1:0]        winner_d;
  logic [ID_W-1:0]        rr_ptr_d;
  logic                   win_write;
  logic [ADDR_W-1:0]      win_addr;
  logic [LINE_W-1:0]      win_wdata;

  assign req     = cli_read_i | cli_write_i;
  assign any_req = |req;

  // Scan NUM_PORTS slots starting at rr_ptr (round-robin) or at 0 (fixed
  // priority); the first requesting slot wins. The wrap is a single
  // subtraction because the start offset is always below NUM_PORTS.
  always_comb begin
    winner_d = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE) begin
        scan_idx = int'(rr_ptr_q) + k;
      end else begin
        scan_idx = k;
      end
      if (scan_idx >= NUM_PORTS) begin
        scan_idx = scan_idx - NUM_PORTS;
      end
      if (!found && req[ID_W'(scan_idx)]) begin
        found    = 1'b1;
        winner_d = ID_W'(scan_idx);
      end
    end
  end

  // Pointer moves to the slot after the winner so the winner becomes the
  // lowest priority for the next decision.
  assign rr_ptr_d  = (winner_d == LAST_ID) ? '0 : winner_d + 1'b1;

  // A client asserting both read and write is treated as a write.
  assign win_write = cli_write_i[winner_d];
  assign win_addr  = cli_address_i[int'(winner_d)*ADDR_W +: ADDR_W];
  assign win_wdata = cli_wdata_i[int'(winner_d)*LINE_W +: LINE_W];

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      op_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      cli_resp_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Response is a single-cycle pulse; it is only set on ISSUE->DONE.
      cli_resp_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_id_q  <= winner_d;
            if (RR_MODE) begin
              rr_ptr_q <= rr_ptr_d;
            end
            op_write_q  <= win_write;
            addr_q      <= win_addr;
            wdata_q     <= win_wdata;
            mem_read_q  <= ~win_write;
            mem_write_q <= win_write;
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Client inputs are not looked at here; the latched request
          // runs to completion regardless of what the client does.
          if (mem_resp_i) begin
            if (!op_write_q) begin
              rdata_q <= mem_rdata_i;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cli_resp_q  <= ONE_HOT_LSB << grant_id_q;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Requests are ignored here; the next decision is taken in IDLE.
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output assignments
  // --------------------------------------------------------------------------
  assign cli_resp_o    = cli_resp_q;
  assign cli_rdata_o   = rdata_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign busy_o        = busy_q;
  assign grant_id_o    = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_rr
// Purpose  : Self-checking bench for mem_arbiter_rr. Two instances with four
//            clients: one round-robin, one fixed priority. Expected client
//            responses are queued when stimulus is applied and compared when
//            the arbiter pulses cli_resp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int LW = 64;
  localparam int AW = 32;

  logic clk;
  logic rst_n;

  // Round-robin instance (a_*)
  logic [N-1:0]    a_read, a_write, a_resp;
  logic [N*AW-1:0] a_addr;
  logic [N*LW-1:0] a_wdata;
  logic [LW-1:0]   a_rdata, a_mwdata, a_mrdata;
  logic [AW-1:0]   a_maddr;
  logic            a_mrd, a_mwr, a_mresp, a_busy;
  logic [1:0]      a_gid;

  // Fixed-priority instance (b_*)
  logic [N-1:0]    b_read, b_write, b_resp;
  logic [N*AW-1:0] b_addr;
  logic [N*LW-1:0] b_wdata;
  logic [LW-1:0]   b_rdata, b_mwdata, b_mrdata;
  logic [AW-1:0]   b_maddr;
  logic            b_mrd, b_mwr, b_mresp, b_busy;
  logic [1:0]      b_gid;

  mem_arbiter_rr #(.NUM_PORTS(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .cli_read_i(a_read), .cli_write_i(a_write), .cli_address_i(a_addr),
    .cli_wdata_i(a_wdata), .cli_resp_o(a_resp), .cli_rdata_o(a_rdata),
    .mem_read_o(a_mrd), .mem_write_o(a_mwr), .mem_address_o(a_maddr),
    .mem_wdata_o(a_mwdata), .mem_resp_i(a_mresp), .mem_rdata_i(a_mrdata),
    .busy_o(a_busy), .grant_id_o(a_gid)
  );

  mem_arbiter_rr #(.NUM_PORTS(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .cli_read_i(b_read), .cli_write_i(b_write), .cli_address_i(b_addr),
    .cli_wdata_i(b_wdata), .cli_resp_o(b_resp), .cli_rdata_o(b_rdata),
    .mem_read_o(b_mrd), .mem_write_o(b_mwr), .mem_address_o(b_maddr),
    .mem_wdata_o(b_mwdata), .mem_resp_i(b_mresp), .mem_rdata_i(b_mrdata),
    .busy_o(b_busy), .grant_id_o(b_gid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboards: one queue of expected responses per instance
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  id;
    logic        wr;
    logic [63:0] line;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  exp_t       ea, eb;
  logic [3:0] a_prev, b_prev;
  int         a_seen = 0;
  int         b_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_prev = '0;
    end else begin
      if (a_prev != 4'b0) check("a_pulse_width", {60'b0, a_resp}, 64'd0);
      if (a_resp != 4'b0) begin
        if (qa.size() == 0) begin
          check("a_unexpected_resp", {60'b0, a_resp}, 64'd0);
        end else begin
          ea = qa.pop_front();
          check("a_resp", {60'b0, a_resp}, {60'b0, 4'b0001 << ea.id});
          check("a_grant_id", {62'b0, a_gid}, {62'b0, ea.id});
          if (!ea.wr) check("a_rdata", a_rdata, ea.line);
          a_seen++;
        end
      end
      a_prev = a_resp;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_prev = '0;
    end else begin
      if (b_prev != 4'b0) check("b_pulse_width", {60'b0, b_resp}, 64'd0);
      if (b_resp != 4'b0) begin
        if (qb.size() == 0) begin
          check("b_unexpected_resp", {60'b0, b_resp}, 64'd0);
        end else begin
          eb = qb.pop_front();
          check("b_resp", {60'b0, b_resp}, {60'b0, 4'b0001 << eb.id});
          check("b_grant_id", {62'b0, b_gid}, {62'b0, eb.id});
          if (!eb.wr) check("b_rdata", b_rdata, eb.line);
          b_seen++;
        end
      end
      b_prev = b_resp;
    end
  end

  // --------------------------------------------------------------------------
  // Auto-responding memory models (enabled per test)
  // --------------------------------------------------------------------------
  bit a_auto = 1'b0;
  bit b_auto = 1'b0;
  int a_lat  = 2;
  int b_lat  = 1;
  int a_cnt  = 0;
  int b_cnt  = 0;

  always begin
    @(posedge clk); #1;
    if (a_auto) begin
      a_mresp = 1'b0;
      if (a_mrd || a_mwr) begin
        if (a_cnt >= a_lat - 1) begin
          a_mresp  = 1'b1;
          a_mrdata = line_of(a_maddr);
          a_cnt    = 0;
        end else begin
          a_cnt++;
        end
      end else begin
        a_cnt = 0;
      end
    end else begin
      a_cnt = 0;
    end
  end

  always begin
    @(posedge clk); #1;
    if (b_auto) begin
      b_mresp = 1'b0;
      if (b_mrd || b_mwr) begin
        if (b_cnt >= b_lat - 1) begin
          b_mresp  = 1'b1;
          b_mrdata = line_of(b_maddr);
          b_cnt    = 0;
        end else begin
          b_cnt++;
        end
      end else begin
        b_cnt = 0;
      end
    end else begin
      b_cnt = 0;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_seen(input bit use_b, input int target, input int budget);
    int cyc;
    cyc = 0;
    while (((use_b ? b_seen : a_seen) < target) && (cyc < budget)) begin
      @(negedge clk); #1;
      cyc++;
    end
    check(use_b ? "b_resp_timeout" : "a_resp_timeout",
          {63'b0, ((use_b ? b_seen : a_seen) >= target)}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    a_read  = '0; a_write = '0; a_addr = '0; a_wdata = '0;
    a_mresp = 1'b0; a_mrdata = '0;
    b_read  = '0; b_write = '0; b_addr = '0; b_wdata = '0;
    b_mresp = 1'b0; b_mrdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- Reset state ----
    @(negedge clk);
    check("rst_busy",     {63'b0, a_busy}, 64'd0);
    check("rst_grant_id", {62'b0, a_gid}, 64'd0);
    check("rst_mem_rw",   {62'b0, a_mrd, a_mwr}, 64'd0);
    check("rst_cli_resp", {60'b0, a_resp}, 64'd0);
    check("rst_cli_rdata", a_rdata, 64'd0);
    check("rst_mem_addr", {32'b0, a_maddr}, 64'd0);

    // ---- Single read, client 1, memory latency 5 ----
    qa.push_back('{id: 2'd1, wr: 1'b0, line: 64'hDEAD_BEEF_CAFE_F00D});
    step();
    a_read[1]           = 1'b1;
    a_addr[1*AW +: AW]  = 32'h0000_1A40;
    @(negedge clk);
    check("rd_c0_mem_read", {63'b0, a_mrd}, 64'd0);
    for (int c = 1; c <= 6; c++) begin
      step();
      a_mresp  = (c == 5);
      a_mrdata = (c == 5) ? 64'hDEAD_BEEF_CAFE_F00D : 64'h0;
      @(negedge clk);
      if (c <= 5) check("rd_mem_read_hi", {63'b0, a_mrd}, 64'd1);
      else        check("rd_mem_read_lo", {63'b0, a_mrd}, 64'd0);
      if (c == 1) check("rd_mem_addr", {32'b0, a_maddr}, 64'h0000_1A40);
      if (c == 6) check("rd_busy_done", {63'b0, a_busy}, 64'd1);
    end
    step();
    a_read = '0;
    a_mresp = 1'b0;
    step();
    @(negedge clk);
    check("rd_rdata_hold", a_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    check("rd_busy_idle", {63'b0, a_busy}, 64'd0);

    // ---- Round-robin, all four clients request continuously ----
    do_reset();
    a_auto = 1'b1;
    a_lat  = 2;
    for (int i = 0; i < N; i++) a_addr[i*AW +: AW] = 32'h1000 * (i + 1);
    qa.push_back('{id: 2'd0, wr: 1'b0, line: line_of(32'h1000)});
    qa.push_back('{id: 2'd1, wr: 1'b0, line: line_of(32'h2000)});
    qa.push_back('{id: 2'd2, wr: 1'b0, line: line_of(32'h3000)});
    qa.push_back('{id: 2'd3, wr: 1'b0, line: line_of(32'h4000)});
    qa.push_back('{id: 2'd0, wr: 1'b0, line: line_of(32'h1000)});
    a_read = 4'b1111;
    wait_seen(1'b0, a_seen + 5, 100);
    step();
    a_read = '0;
    repeat (4) step();
    @(negedge clk);
    check("rr_queue_empty", 64'(qa.size()), 64'd0);
    check("rr_busy_idle", {63'b0, a_busy}, 64'd0);
    a_auto = 1'b0;
    a_mresp = 1'b0;

    // ---- Fixed priority: clients 0 and 2 request continuously ----
    do_reset();
    b_auto = 1'b1;
    b_lat  = 1;
    b_addr[0*AW +: AW] = 32'h0000_0100;
    b_addr[2*AW +: AW] = 32'h0000_0300;
    for (int i = 0; i < 3; i++) qb.push_back('{id: 2'd0, wr: 1'b0, line: line_of(32'h0100)});
    b_read = 4'b0101;
    wait_seen(1'b1, b_seen + 3, 60);
    step();
    b_read[0] = 1'b0;
    qb.push_back('{id: 2'd2, wr: 1'b0, line: line_of(32'h0300)});
    wait_seen(1'b1, b_seen + 1, 30);
    step();
    b_read = '0;
    repeat (3) step();
    @(negedge clk);
    check("fp_queue_empty", 64'(qb.size()), 64'd0);
    b_auto = 1'b0;
    b_mresp = 1'b0;

    // ---- Request stability: client 0 write changes inputs during ISSUE ----
    do_reset();
    qa.push_back('{id: 2'd0, wr: 1'b1, line: 64'h0});
    step();
    a_write[0]          = 1'b1;
    a_addr[0*AW +: AW]  = 32'h0000_2000;
    a_wdata[0*LW +: LW] = 64'hA5A5_0000_5A5A_1111;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin
        a_addr[0*AW +: AW] = 32'hFFFF_FFFF;
        a_write[0]         = 1'b0;
      end
      a_mresp  = (c == 4);
      a_mrdata = 64'h1234_5678_9ABC_DEF0;
      @(negedge clk);
      if (c <= 4) begin
        check("st_mem_write", {63'b0, a_mwr}, 64'd1);
        check("st_mem_read",  {63'b0, a_mrd}, 64'd0);
        check("st_mem_addr",  {32'b0, a_maddr}, 64'h0000_2000);
        check("st_mem_wdata", a_mwdata, 64'hA5A5_0000_5A5A_1111);
      end else begin
        check("st_mem_write_done", {63'b0, a_mwr}, 64'd0);
        check("st_rdata_kept", a_rdata, 64'd0);
      end
    end
    step();
    a_mresp = 1'b0;
    step();

    // ---- Reset asserted two cycles into ISSUE ----
    do_reset();
    step();
    a_read[1]          = 1'b1;
    a_addr[1*AW +: AW] = 32'h0000_0ABC;
    step();          // cycle 1, ISSUE
    step();          // cycle 2, ISSUE
    @(negedge clk);
    check("mr_pre_busy", {63'b0, a_busy}, 64'd1);
    step();
    rst_n = 1'b0;
    #1;
    check("mr_mem_read", {63'b0, a_mrd}, 64'd0);
    check("mr_busy",     {63'b0, a_busy}, 64'd0);
    check("mr_cli_resp", {60'b0, a_resp}, 64'd0);
    a_read = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    a_mresp = 1'b1;
    step();
    a_mresp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mr_idle_busy", {63'b0, a_busy}, 64'd0);
      check("mr_idle_resp", {60'b0, a_resp}, 64'd0);
      check("mr_idle_mem",  {62'b0, a_mrd, a_mwr}, 64'd0);
      step();
    end

    // ---- Read+write on one client plus spurious mem_resp in IDLE ----
    a_mresp = 1'b1;
    @(negedge clk);
    check("sp_idle_busy", {63'b0, a_busy}, 64'd0);
    step();
    a_read[3]           = 1'b1;
    a_write[3]          = 1'b1;
    a_addr[3*AW +: AW]  = 32'h0000_3000;
    a_wdata[3*LW +: LW] = 64'h0F0F_F0F0_1234_4321;
    a_mresp             = 1'b1;
    qa.push_back('{id: 2'd3, wr: 1'b1, line: 64'h0});
    @(negedge clk);
    check("sp_c0_busy", {63'b0, a_busy}, 64'd0);
    step();
    a_mresp = 1'b0;
    @(negedge clk);
    check("rw_mem_write", {63'b0, a_mwr}, 64'd1);
    check("rw_mem_read",  {63'b0, a_mrd}, 64'd0);
    check("rw_mem_addr",  {32'b0, a_maddr}, 64'h0000_3000);
    check("rw_mem_wdata", a_mwdata, 64'h0F0F_F0F0_1234_4321);
    check("rw_grant_id",  {62'b0, a_gid}, 64'd3);
    step();
    @(negedge clk);
    check("sp_c2_busy", {63'b0, a_busy}, 64'd1);
    check("sp_c2_resp", {60'b0, a_resp}, 64'd0);
    step();
    a_mresp = 1'b1;
    step();
    a_mresp = 1'b0;
    a_read  = '0;
    a_write = '0;
    repeat (3) step();
    @(negedge clk);
    check("final_qa_empty", 64'(qa.size()), 64'd0);
    check("final_qb_empty", 64'(qb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-client arbiter between L1 caches and one line-wide downstream memory (physical memory or L2).
- Successor to the fixed two-port icache/dcache arbiter.
- Adds: configurable client count and line width; round-robin or fixed-priority mode; registered downstream request; registered client response.

Parameters:
- NUM_PORTS, 2, number of clients (2..8); port 0 = icache and port 1 = dcache by convention.
- LINE_W, 256, line width in bits for rdata/wdata.
- ADDR_W, 32, address width.
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cli_read  in  NUM_PORTS  per-client line read request, level, held until cli_resp.
- cli_write  in  NUM_PORTS  per-client line write request, level, held until cli_resp.
- cli_address  in  NUM_PORTS*ADDR_W  client i address at bits [i*ADDR_W +: ADDR_W].
- cli_wdata  in  NUM_PORTS*LINE_W  client i write line at bits [i*LINE_W +: LINE_W].
- cli_resp  out  NUM_PORTS  one-cycle completion pulse to granted client.
- cli_rdata  out  LINE_W  read line, valid in the cli_resp cycle; shared by all clients.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  LINE_W  downstream write line.
- mem_resp  in  1  downstream completion, one cycle.
- mem_rdata  in  LINE_W  downstream read data, valid with mem_resp.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NUM_PORTS), min 1  index of the client currently or last served.

Behaviour:
- States:
  - IDLE: no transaction outstanding.
  - ISSUE: downstream request driven.
  - DONE: client response cycle.
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All outputs 0; cli_rdata=0; latched address/wdata/op = 0.
- IDLE:
  - req[i] = cli_read[i] | cli_write[i].
  - If any req: pick winner, latch address, wdata and op; write wins if a client asserts both read and write.
  - Go to ISSUE; update grant_id.
- Winner selection:
  - RR_MODE=1: first requesting index at or after rr_ptr, scanning upward with wrap-around modulo NUM_PORTS. On grant, rr_ptr = winner+1, wrapping NUM_PORTS-1 to 0.
  - RR_MODE=0: lowest requesting index; rr_ptr unused.
- ISSUE:
  - mem_read/mem_write, mem_address and mem_wdata are driven from registers only; stable for the whole transaction, independent of client inputs.
  - Client dropping or changing its request during ISSUE has no effect; the transaction completes.
  - On mem_resp: capture mem_rdata into cli_rdata, go to DONE.
  - mem_read/mem_write deassert in DONE.
- DONE:
  - cli_resp[grant_id]=1 for exactly one cycle; all other cli_resp bits 0.
  - cli_rdata holds the captured line; it is also held after DONE until the next capture.
  - For writes, cli_rdata is don't-care and keeps its previous value.
  - Next state IDLE; the new arbitration decision is made in that IDLE cycle.
  - The just-served client must deassert its request in the cycle after cli_resp; the arbiter ignores requests during DONE.
- Latency:
  - Request first seen in IDLE at cycle 0 -> mem_read/mem_write high from cycle 1.
  - mem_resp in cycle k -> cli_resp in cycle k+1.
  - Minimum 3 cycles per transaction; back-to-back grants are separated by one IDLE cycle.
- mem_resp while in IDLE or DONE: ignored.
- Reset asserted mid-ISSUE: transaction abandoned, outputs clear immediately, and no cli_resp is issued.
- Fairness: in RR_MODE=1 a continuously requesting client waits at most NUM_PORTS-1 other grants.

Test Plan:
- Single read, NUM_PORTS=2: client 1 reads 0x0000_1A40, memory responds after 5 cycles with line 0xDEAD... -> mem_read high cycles 1-5, mem_address=0x0000_1A40, cli_resp=2'b10 in cycle 6 with that line on cli_rdata, grant_id=1.
- Round-robin, NUM_PORTS=4, all four request continuously -> grant order 0,1,2,3,0; rr_ptr wraps 3->0; each cli_resp is a single-cycle pulse.
- Fixed priority (RR_MODE=0), clients 0 and 2 request continuously -> client 0 always wins; client 2 is served only after client 0 drops its request.
- Request stability: client 0 write of 0x0000_2000 granted, then client changes cli_address to 0xFFFF_FFFF and drops cli_write during ISSUE -> mem_address stays 0x0000_2000, mem_write held until mem_resp, cli_resp[0] still pulses.
- Reset mid-transaction: assert rst_n=0 two cycles into ISSUE -> mem_read=0, busy=0, cli_resp=0 immediately; after release with no requests, arbiter remains IDLE and a stray mem_resp is ignored.
- Read+write on same client plus spurious mem_resp in IDLE -> write issued (mem_write=1, mem_read=0); the IDLE-cycle mem_resp causes no state change.
